eaglesong_bit_matrix_sched: RTL and testbench

//  Sequencer for the Eaglesong bit-matrix step: new[j] = XOR over k of (M[k*16+j] ? state[k] : 0).

---
 rtl/eaglesong_bit_matrix_sched.sv | 120 ++++++++++++
 tb/tb_eaglesong_bit_matrix_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_bit_matrix_sched.sv
// Eaglesong bit-matrix step sequencer: walks all 256 (k,j) pairs through one shared
// single-bit matrix lookup and returns new[j] = XOR_k (M[k*16+j] ? state[k] : 0).
module eaglesong_bit_matrix_sched #(
    parameter int WORD_W     = 32,
    parameter bit LOOKUP_REG = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*WORD_W-1:0] state_in,
    output logic                 busy,
    output logic [7:0]           bm_index,
    input  logic                 bm_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*WORD_W-1:0] state_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t              fsm;
    logic [3:0]        k, j;
    logic              issue_done;
    logic              pend;
    logic [3:0]        pk, pj;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] words [16];
    logic [WORD_W-1:0] mix   [15];

    logic                 issuing, acc_en, acc_last_k, acc_last;
    logic [3:0]           acc_k, acc_j;
    logic [WORD_W-1:0]    acc_n;
    logic [16*WORD_W-1:0] final_vec;

    // The accumulate side either tracks the issue side directly or lags it by the lookup's register stage.
    // NOTE: combinational logic uses blocking '=', with every output given a value on every path so no latch is inferred.
    always_comb begin
        issuing = (fsm == RUN) && !issue_done;
        if (LOOKUP_REG) begin
            acc_en = pend;
            acc_k  = pk;
            acc_j  = pj;
        end else begin
            acc_en = issuing;
            acc_k  = k;
            acc_j  = j;
        end
        acc_n      = acc ^ (bm_bit ? words[acc_k] : '0);
        acc_last_k = acc_en && (acc_k == 4'd15);
        acc_last   = acc_last_k && (acc_j == 4'd15);
        final_vec  = '0;
        for (int i = 0; i < 15; i++) final_vec[WORD_W*i +: WORD_W] = mix[i];
        final_vec[WORD_W*15 +: WORD_W] = acc_n;
    end

    assign bm_index = issuing ? {k, j} : 8'd0;

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            k          <= 4'd0;
            j          <= 4'd0;
            acc        <= '0;
            issue_done <= 1'b0;
            pend       <= 1'b0;
            pk         <= 4'd0;
            pj         <= 4'd0;
            state_out  <= '0;
        end else begin
            pend <= issuing;
            pk   <= k;
            pj   <= j;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        fsm        <= RUN;
                        busy       <= 1'b1;
                        k          <= 4'd0;
                        j          <= 4'd0;
                        acc        <= '0;
                        issue_done <= 1'b0;
                    end
                end
                RUN: begin
                    if (issuing) begin
                        k <= k + 4'd1;
                        if (k == 4'd15) begin
                            j <= j + 4'd1;
                            if (j == 4'd15) issue_done <= 1'b1;
                        end
                    end
                    if (acc_en) acc <= acc_last_k ? '0 : acc_n;
                    if (acc_last) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        state_out <= final_vec;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // NOTE: captured words and partial results are always written before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fsm == IDLE && start) begin
            for (int i = 0; i < 16; i++) words[i] <= state_in[WORD_W*i +: WORD_W];
        end
        if (acc_last_k && acc_j != 4'd15) mix[acc_j] <= acc_n;
    end
endmodule

// File: tb/tb_eaglesong_bit_matrix_sched.sv
// Bench for eaglesong_bit_matrix_sched: both lookup modes, table-driven vectors plus
// hold, mid-run reset and back-to-back sequences.
module tb_eaglesong_bit_matrix_sched;
    localparam int W  = 32;
    localparam int SW = 16 * W;
    localparam int NV = 12;

    // Eaglesong bit matrix, row k written j=0..15 left to right.
    localparam logic [15:0] M_ROWS [16] = '{
        16'b1111010111110001, 16'b0111101011111001, 16'b0011110101111101, 16'b0001111010111111,
        16'b1111101010101110, 16'b1000110000000111, 16'b0100011000000011, 16'b0010001100000001,
        16'b1110000001110000, 16'b0111000000111000, 16'b0011100000011100, 16'b0001110000001110,
        16'b1111000111110110, 16'b1000010100001011, 16'b0100001010000101, 16'b0010000101000011
    };

    typedef struct {
        logic [SW-1:0] st;
        logic [SW-1:0] exp;
        bit            chk_idx;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, out_ready;
    logic [SW-1:0] state_in;
    int            cur;
    int            n_tests, n_fail;
    vec_t          vecs [NV];

    logic          start0, start1;
    logic          busy0, busy1, valid0, valid1;
    logic [7:0]    index0, index1;
    logic          bm_bit0;
    logic          bm_bit1 = 1'b0;
    logic [SW-1:0] out0, out1;

    logic          sel_busy, sel_valid;
    logic [7:0]    sel_index;
    logic [SW-1:0] sel_out;

    always #5 clk = ~clk;

    function automatic logic mbit(input logic [7:0] idx);
        logic [15:0] row;
        row = M_ROWS[idx[7:4]];
        return row[4'd15 - idx[3:0]];
    endfunction

    function automatic logic [SW-1:0] ref_mix(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++)
                if (mbit(8'(k * 16 + j))) r[W*j +: W] = r[W*j +: W] ^ s[W*k +: W];
        return r;
    endfunction

    function automatic logic [SW-1:0] place(input int k, input logic [W-1:0] w);
        logic [SW-1:0] r;
        r = '0;
        r[W*k +: W] = w;
        return r;
    endfunction

    function automatic logic [SW-1:0] spread(input logic [15:0] mask, input logic [W-1:0] w);
        logic [SW-1:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) if (mask[j]) r[W*j +: W] = w;
        return r;
    endfunction

    assign start0  = start && (cur == 0);
    assign start1  = start && (cur == 1);
    assign bm_bit0 = mbit(index0);
    always @(posedge clk) bm_bit1 <= mbit(index1);

    always_comb begin
        sel_busy  = (cur == 1) ? busy1  : busy0;
        sel_valid = (cur == 1) ? valid1 : valid0;
        sel_index = (cur == 1) ? index1 : index0;
        sel_out   = (cur == 1) ? out1   : out0;
    end

    eaglesong_bit_matrix_sched #(.WORD_W(W), .LOOKUP_REG(1'b0)) u_lr0 (
        .clk(clk), .rst(rst), .start(start0), .state_in(state_in), .busy(busy0),
        .bm_index(index0), .bm_bit(bm_bit0), .out_valid(valid0), .out_ready(out_ready),
        .state_out(out0)
    );

    eaglesong_bit_matrix_sched #(.WORD_W(W), .LOOKUP_REG(1'b1)) u_lr1 (
        .clk(clk), .rst(rst), .start(start1), .state_in(state_in), .busy(busy1),
        .bm_index(index1), .bm_bit(bm_bit1), .out_valid(valid1), .out_ready(out_ready),
        .state_out(out1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lr%0d %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    // Start one run from IDLE and wait (bounded) for the result.
    task automatic run_vec(input string name, input logic [SW-1:0] st, input logic [SW-1:0] exp,
                           input bit chk_idx);
        int lat, bad;
        state_in = st;
        start    = 1'b1;
        step();
        start    = 1'b0;
        state_in = ~st;
        lat = 0;
        bad = 0;
        while (!sel_valid && lat < 400) begin
            if (chk_idx && lat < 256 && sel_index !== 8'((lat % 16) * 16 + lat / 16)) bad++;
            step();
            lat++;
        end
        check({name, " latency"}, SW'(lat), SW'(256 + cur));
        check({name, " result"}, sel_out, exp);
        if (chk_idx) check({name, " index order"}, SW'(bad), SW'(0));
    endtask

    task automatic end_vec(input string name);
        out_ready = 1'b1;
        step();
        check({name, " valid drop"}, SW'(sel_valid), SW'(0));
        check({name, " busy drop"}, SW'(sel_busy), SW'(0));
    endtask

    initial begin
        int t, t_a, bad;
        n_tests   = 0;
        n_fail    = 0;
        cur       = 0;
        start     = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        rst       = 1'b1;

        vecs[0] = '{place(0, 32'hFFFFFFFF), spread(16'h8FAF, 32'hFFFFFFFF), 1'b0};
        vecs[1] = '{'0, '0, 1'b1};
        vecs[2] = '{place(1, 32'h12345678), spread(16'h9F5E, 32'h12345678), 1'b0};
        vecs[3] = '{place(0, 32'hFFFF0000) | place(1, 32'h0000FFFF),
                    spread(16'h8FAF, 32'hFFFF0000) ^ spread(16'h9F5E, 32'h0000FFFF), 1'b0};
        for (int i = 4; i < NV; i++) begin
            for (int w = 0; w < 16; w++) vecs[i].st[W*w +: W] = $urandom();
            vecs[i].exp     = ref_mix(vecs[i].st);
            vecs[i].chk_idx = 1'b0;
        end

        for (int d = 0; d < 2; d++) begin
            cur = d;
            rst = 1'b1;
            step();
            check("reset busy", SW'(sel_busy), SW'(0));
            check("reset valid", SW'(sel_valid), SW'(0));
            check("reset index", SW'(sel_index), SW'(0));
            check("reset state_out", sel_out, '0);
            rst = 1'b0;
            step();

            for (int i = 0; i < NV; i++) begin
                run_vec($sformatf("vec%0d", i), vecs[i].st, vecs[i].exp, vecs[i].chk_idx);
                end_vec($sformatf("vec%0d", i));
            end

            // Result held in DONE with ready low; a start pulse there must not launch a run.
            out_ready = 1'b0;
            run_vec("hold", vecs[2].st, vecs[2].exp, 1'b0);
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                start = (c == 4);
                step();
                if (sel_valid !== 1'b1 || sel_busy !== 1'b1 || sel_out !== vecs[2].exp) bad++;
            end
            start = 1'b0;
            check("hold stable", SW'(bad), SW'(0));
            end_vec("hold");
            step();
            check("hold no new run", SW'(sel_busy), SW'(0));

            // Reset in the middle of a run, then a clean restart.
            state_in = vecs[0].st;
            start    = 1'b1;
            step();
            start    = 1'b0;
            repeat (100) step();
            #1 rst = 1'b1;
            #1;
            check("abort busy", SW'(sel_busy), SW'(0));
            check("abort valid", SW'(sel_valid), SW'(0));
            check("abort index", SW'(sel_index), SW'(0));
            check("abort state_out", sel_out, '0);
            step();
            rst = 1'b0;
            step();
            run_vec("restart", vecs[0].st, vecs[0].exp, 1'b0);
            end_vec("restart");

            // Start held high: back-to-back runs.
            state_in = vecs[3].st;
            start    = 1'b1;
            t = 0;
            while (!sel_valid && t < 1000) begin step(); t++; end
            t_a = t;
            check("b2b first result", sel_out, vecs[3].exp);
            while (sel_valid && t < 1000) begin step(); t++; end
            while (!sel_valid && t < 1000) begin step(); t++; end
            start = 1'b0;
            check("b2b period", SW'(t - t_a), SW'(258 + cur));
            check("b2b second result", sel_out, vecs[3].exp);
            t = 0;
            while (sel_busy && t < 10) begin step(); t++; end
            check("b2b idle", SW'(sel_busy), SW'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
